// File: rtl/pipeline_ctrl_if.sv
// Decode/execute/writeback handshake bundle for the issue controller.
// master drives decode and writeback, slave is the controller.
interface pipeline_ctrl_if #(
    parameter int IDX = 4
);
    logic           dec_valid;
    logic [IDX-1:0] dec_rd;
    logic [IDX-1:0] dec_rs;
    logic [IDX-1:0] dec_rt;
    logic           dec_uses_rs;
    logic           dec_uses_rt;
    logic           dec_writes_rd;
    logic           dec_is_cmp;
    logic           dec_is_cjmp;
    logic           dec_is_call_ret;
    logic           exe_taken;
    logic           wb_rd_write_en;
    logic [IDX-1:0] wb_rd_num;
    logic           wb_cpsr_write_en;
    logic           dec_ready;
    logic           exe_issue;
    logic           pc_hold;
    logic           flush;

    modport master (
        output dec_valid, dec_rd, dec_rs, dec_rt,
        output dec_uses_rs, dec_uses_rt, dec_writes_rd,
        output dec_is_cmp, dec_is_cjmp, dec_is_call_ret,
        output exe_taken, wb_rd_write_en, wb_rd_num,
        output wb_cpsr_write_en,
        input  dec_ready, exe_issue, pc_hold, flush
    );

    modport slave (
        input  dec_valid, dec_rd, dec_rs, dec_rt,
        input  dec_uses_rs, dec_uses_rt, dec_writes_rd,
        input  dec_is_cmp, dec_is_cjmp, dec_is_call_ret,
        input  exe_taken, wb_rd_write_en, wb_rd_num,
        input  wb_cpsr_write_en,
        output dec_ready, exe_issue, pc_hold, flush
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Issue/hazard controller: register/CPSR scoreboard, call/ret drain, jump flush.
// Optional PIPELINE_PERF_EN adds saturating stall_cycles/flush_events counters.
module pipeline_ctrl #(
    parameter int NUM_REGS    = 16,
    parameter int FLUSH_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    pipeline_ctrl_if.slave bus
`ifdef PIPELINE_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);
    localparam int CW = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_REGS-1:0] busy, busy_n, wb_clear, set_vec, eff_busy;
    logic cpsr_busy, eff_cpsr_busy;
    logic haz, empty, ready_c, flush_c;

    assign wb_clear = bus.wb_rd_write_en ? (NUM_REGS'(1) << bus.wb_rd_num)
                                         : '0;
    assign set_vec  = (bus.exe_issue && bus.dec_writes_rd)
                    ? (NUM_REGS'(1) << bus.dec_rd) : '0;
    assign eff_busy      = busy & ~wb_clear;
    assign eff_cpsr_busy = cpsr_busy & ~bus.wb_cpsr_write_en;

    assign haz = (bus.dec_uses_rs   & eff_busy[bus.dec_rs])
               | (bus.dec_uses_rt   & eff_busy[bus.dec_rt])
               | (bus.dec_writes_rd & eff_busy[bus.dec_rd])
               | (bus.dec_is_cjmp   & eff_cpsr_busy);
    assign empty = (eff_busy == '0) & ~eff_cpsr_busy;

    // Set after clear so a same-cycle reissue of a retiring register wins.
    assign busy_n = eff_busy | set_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= '0;
            cpsr_busy <= 1'b0;
        end else begin
            busy      <= busy_n;
            cpsr_busy <= (bus.exe_issue & bus.dec_is_cmp) | eff_cpsr_busy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_RUN: begin
                if (bus.exe_taken) begin
                    state_n = S_FLUSH;
                    cnt_n   = CW'(FLUSH_DEPTH - 1);
                end else if (bus.dec_valid && bus.dec_is_call_ret && !empty) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.exe_taken) begin
                    state_n = S_FLUSH;
                    cnt_n   = CW'(FLUSH_DEPTH - 1);
                end else if (empty) begin
                    state_n = S_RUN;
                end
            end
            S_FLUSH: begin
                if (cnt == '0) state_n = S_RUN;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = S_RUN;
        endcase
    end

    always_comb begin
        ready_c = 1'b0;
        flush_c = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.exe_taken)                             flush_c = 1'b1;
                else if (bus.dec_is_call_ret && bus.dec_valid && !empty) ready_c = 1'b0;
                else                                           ready_c = ~haz;
            end
            S_DRAIN: flush_c = bus.exe_taken;
            S_FLUSH: flush_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.dec_ready = ~reset & ready_c;
    assign bus.exe_issue = bus.dec_valid & bus.dec_ready;
    assign bus.flush     = ~reset & flush_c;
    assign bus.pc_hold   = ~reset & bus.dec_valid & ~bus.dec_ready
                         & (state != S_FLUSH)
                         & ~((state == S_RUN) & bus.exe_taken);

`ifdef PIPELINE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (bus.pc_hold && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (state != S_FLUSH && state_n == S_FLUSH && flush_events != '1)
                flush_events <= flush_events + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, drain, flush, set-wins, reset.
// Output vector order is {dec_ready, exe_issue, pc_hold, flush}.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    pipeline_ctrl_if #(.IDX(4)) bus ();

`ifdef PIPELINE_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    pipeline_ctrl #(.NUM_REGS(16), .FLUSH_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPELINE_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {bus.dec_ready, bus.exe_issue, bus.pc_hold, bus.flush};
    endfunction

    task automatic clr();
        bus.dec_valid = 0; bus.dec_rd = 0; bus.dec_rs = 0; bus.dec_rt = 0;
        bus.dec_uses_rs = 0; bus.dec_uses_rt = 0; bus.dec_writes_rd = 0;
        bus.dec_is_cmp = 0; bus.dec_is_cjmp = 0; bus.dec_is_call_ret = 0;
        bus.exe_taken = 0; bus.wb_rd_write_en = 0; bus.wb_rd_num = 0;
        bus.wb_cpsr_write_en = 0;
    endtask

    // Start a new cycle on the falling edge with all inputs idle.
    task automatic cyc();
        @(negedge clk);
        clr();
    endtask

    task automatic dec(input logic v, input logic [3:0] rd, rs, rt,
                       input logic urs, urt, wr);
        bus.dec_valid = v; bus.dec_rd = rd; bus.dec_rs = rs; bus.dec_rt = rt;
        bus.dec_uses_rs = urs; bus.dec_uses_rt = urt; bus.dec_writes_rd = wr;
    endtask

    task automatic wb(input logic [3:0] n);
        bus.wb_rd_write_en = 1; bus.wb_rd_num = n;
    endtask

    task automatic test_reset();
        clr();
        reset = 1;
        dec(1, 4'd1, 4'd2, 4'd3, 1, 1, 1);
        #1;
        checks++; if (outs() !== 4'b0000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs(), 4'b0000); end
        cyc(); cyc();
        reset = 0;
        dec(0, 4'd1, 4'd1, 4'd1, 1, 1, 1); bus.dec_is_cjmp = 1; #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL reset_clear got=%b exp=%b", outs(), 4'b1000); end
    endtask

    task automatic test_raw();
        cyc(); dec(1, 4'd1, 4'd2, 4'd3, 1, 1, 1); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL raw_producer got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(1, 4'd4, 4'd1, 4'd5, 1, 1, 1); #1;
        checks++; if (outs() !== 4'b0010) begin failures++; $display("FAIL raw_stall got=%b exp=%b", outs(), 4'b0010); end
        cyc(); dec(1, 4'd4, 4'd1, 4'd5, 1, 1, 1); wb(4'd1); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL raw_wb_issue got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(0, 4'd0, 4'd4, 4'd0, 1, 0, 0); #1;
        checks++; if (outs() !== 4'b0000) begin failures++; $display("FAIL raw_r4_busy got=%b exp=%b", outs(), 4'b0000); end
        cyc(); dec(0, 4'd0, 4'd4, 4'd0, 1, 0, 0); wb(4'd4); #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL raw_r4_clear got=%b exp=%b", outs(), 4'b1000); end
    endtask

    task automatic test_cpsr();
        cyc(); dec(1, 4'd0, 4'd1, 4'd2, 1, 1, 0); bus.dec_is_cmp = 1; #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL cmp_issue got=%b exp=%b", outs(), 4'b1100); end
        for (int i = 0; i < 2; i++) begin
            cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_cjmp = 1; #1;
            checks++; if (outs() !== 4'b0010) begin failures++; $display("FAIL cjmp_stall%0d got=%b exp=%b", i, outs(), 4'b0010); end
        end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_cjmp = 1;
        bus.wb_cpsr_write_en = 1; #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL cjmp_wb_issue got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(1, 4'd0, 4'd1, 4'd2, 1, 1, 0); bus.dec_is_cmp = 1; #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL cmp2_issue got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL jmp_uncond got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(0, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_cjmp = 1; #1;
        checks++; if (outs() !== 4'b0000) begin failures++; $display("FAIL cpsr_still_busy got=%b exp=%b", outs(), 4'b0000); end
        cyc(); bus.dec_is_cjmp = 1; bus.wb_cpsr_write_en = 1; #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL cpsr_clear got=%b exp=%b", outs(), 4'b1000); end
    endtask

    task automatic test_flush();
        cyc(); dec(1, 4'd9, 4'd0, 4'd0, 0, 0, 1); bus.exe_taken = 1; #1;
        checks++; if (outs() !== 4'b0001) begin failures++; $display("FAIL flush_taken got=%b exp=%b", outs(), 4'b0001); end
        cyc(); dec(1, 4'd9, 4'd0, 4'd0, 0, 0, 1); bus.exe_taken = 1; #1;
        checks++; if (outs() !== 4'b0001) begin failures++; $display("FAIL flush_cyc1 got=%b exp=%b", outs(), 4'b0001); end
        cyc(); dec(1, 4'd9, 4'd0, 4'd0, 0, 0, 1); #1;
        checks++; if (outs() !== 4'b0001) begin failures++; $display("FAIL flush_cyc2 got=%b exp=%b", outs(), 4'b0001); end
        cyc(); dec(0, 4'd9, 4'd9, 4'd0, 1, 0, 1); #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL flush_back_run got=%b exp=%b", outs(), 4'b1000); end
    endtask

    task automatic test_drain();
        cyc(); dec(1, 4'd6, 4'd0, 4'd0, 1, 0, 1); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL drain_ld got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_call_ret = 1; #1;
        checks++; if (outs() !== 4'b0010) begin failures++; $display("FAIL drain_enter got=%b exp=%b", outs(), 4'b0010); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_call_ret = 1; #1;
        checks++; if (outs() !== 4'b0010) begin failures++; $display("FAIL drain_wait got=%b exp=%b", outs(), 4'b0010); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_call_ret = 1; wb(4'd6); #1;
        checks++; if (outs() !== 4'b0010) begin failures++; $display("FAIL drain_wb got=%b exp=%b", outs(), 4'b0010); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); bus.dec_is_call_ret = 1; #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL drain_call_issue got=%b exp=%b", outs(), 4'b1100); end
    endtask

    task automatic test_set_wins();
        cyc(); dec(1, 4'd8, 4'd0, 4'd0, 0, 0, 1); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL setwin_ld1 got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(1, 4'd8, 4'd0, 4'd0, 0, 0, 1); wb(4'd8); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL setwin_ld2 got=%b exp=%b", outs(), 4'b1100); end
        cyc(); dec(0, 4'd0, 4'd8, 4'd0, 1, 0, 0); #1;
        checks++; if (outs() !== 4'b0000) begin failures++; $display("FAIL setwin_busy got=%b exp=%b", outs(), 4'b0000); end
        cyc(); dec(0, 4'd0, 4'd8, 4'd0, 1, 0, 0); wb(4'd8); #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL setwin_clear got=%b exp=%b", outs(), 4'b1000); end
    endtask

    task automatic test_reset_mid();
`ifdef PIPELINE_PERF_EN
        cyc(); #1;
        checks++; if (stall_cycles !== 32'd6) begin failures++; $display("FAIL perf_stalls got=%0d exp=%0d", stall_cycles, 6); end
        checks++; if (flush_events !== 16'd1) begin failures++; $display("FAIL perf_flushes got=%0d exp=%0d", flush_events, 1); end
`endif
        cyc(); dec(1, 4'd10, 4'd0, 4'd0, 0, 0, 1); #1;
        checks++; if (outs() !== 4'b1100) begin failures++; $display("FAIL mid_issue got=%b exp=%b", outs(), 4'b1100); end
        cyc(); bus.exe_taken = 1; #1;
        checks++; if (outs() !== 4'b0001) begin failures++; $display("FAIL mid_taken got=%b exp=%b", outs(), 4'b0001); end
        cyc(); dec(1, 4'd0, 4'd0, 4'd0, 0, 0, 0); #1;
        reset = 1; #1;
        checks++; if (outs() !== 4'b0000) begin failures++; $display("FAIL mid_reset_outs got=%b exp=%b", outs(), 4'b0000); end
        cyc(); reset = 0;
        dec(0, 4'd10, 4'd10, 4'd0, 1, 0, 1); #1;
        checks++; if (outs() !== 4'b1000) begin failures++; $display("FAIL mid_after_reset got=%b exp=%b", outs(), 4'b1000); end
`ifdef PIPELINE_PERF_EN
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL perf_stalls_rst got=%0d exp=%0d", stall_cycles, 0); end
        checks++; if (flush_events !== 16'd0) begin failures++; $display("FAIL perf_flushes_rst got=%0d exp=%0d", flush_events, 0); end
`endif
    endtask

    initial begin
        test_reset();
        test_raw();
        test_cpsr();
        test_flush();
        test_drain();
        test_set_wins();
        test_reset_mid();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
